// File: rtl/ce_gen_prog.sv
// Two-stage clock-enable generator: free-running prescaler plus a programmable
// periodic/one-shot strobe stage. Optional define: CE_GEN_RESYNC_EN (start re-phases the prescaler).
module ce_gen_prog #(
  parameter int FCLK  = 50000000,
  parameter int FBASE = 1000,
  parameter int PW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic          mode,
  input  logic [PW-1:0] period,
  output logic          ce_base,
  output logic          ce_out,
  output logic          busy,
  output logic [PW-1:0] remain
);

  localparam int DIV = FCLK / FBASE;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] PC_TOP = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_chk
    $error("ce_gen_prog: FCLK/FBASE must be at least 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] pc_q, pc_d;
  logic [PW-1:0] dc_q, dc_d;
  logic [PW-1:0] plen_q, plen_d;
  logic          pmode_q, pmode_d;
  logic          busy_q, busy_d;

  logic pc_zero;
  logic dc_zero;
  logic run;

  assign pc_zero = (pc_q == '0);
  assign dc_zero = (dc_q == '0);
  assign run     = (state_q == RUN);

  assign ce_base = en & pc_zero;
  assign ce_out  = en & run & dc_zero & pc_zero & ~start;
  assign busy    = busy_q;
  assign remain  = dc_q;

  always_comb begin
    pc_d = pc_q;
    if (en) begin
      pc_d = pc_zero ? PC_TOP : pc_q - CW'(1);
    end
`ifdef CE_GEN_RESYNC_EN
    if (start) begin
      pc_d = PC_TOP;
    end
`else
`endif
  end

  always_comb begin
    state_d = state_q;
    dc_d    = dc_q;
    plen_d  = plen_q;
    pmode_d = pmode_q;
    unique case (state_q)
      IDLE: begin
        if (start && period != '0) begin
          plen_d  = period;
          pmode_d = mode;
          dc_d    = period - PW'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        // a restart swallows any base strobe of the same cycle
        if (start) begin
          if (period != '0) begin
            plen_d  = period;
            pmode_d = mode;
            dc_d    = period - PW'(1);
          end else begin
            dc_d    = '0;
            state_d = IDLE;
          end
        end else if (ce_base) begin
          if (!dc_zero) begin
            dc_d = dc_q - PW'(1);
          end else if (pmode_q) begin
            state_d = IDLE;
          end else begin
            dc_d = plen_q - PW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= PC_TOP;
      dc_q    <= '0;
      plen_q  <= '0;
      pmode_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      dc_q    <= dc_d;
      plen_q  <= plen_d;
      pmode_q <= pmode_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_ce_gen_prog.sv
// Directed bench for ce_gen_prog with DIV=10, PW=8.
// Expected cycles shift by one when the resync option is not built in.
module tb_ce_gen_prog;

  localparam int PW = 8;
`ifdef CE_GEN_RESYNC_EN
  localparam int SH = 0;
`else
  localparam int SH = 1;
`endif

  logic          clk;
  logic          rst;
  logic          en;
  logic          start;
  logic          mode;
  logic [PW-1:0] period;
  logic          ce_base;
  logic          ce_out;
  logic          busy;
  logic [PW-1:0] remain;

  int vecs;
  int errs;

  ce_gen_prog #(
    .FCLK (10),
    .FBASE(1),
    .PW   (PW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .start  (start),
    .mode   (mode),
    .period (period),
    .ce_base(ce_base),
    .ce_out (ce_out),
    .busy   (busy),
    .remain (remain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // leaves the bench at the start of cycle 0
  task automatic do_reset();
    rst    = 1'b1;
    en     = 1'b1;
    start  = 1'b0;
    mode   = 1'b0;
    period = '0;
    step();
    rst = 1'b0;
  endtask

  function automatic bit base_exp(int c, int s);
`ifdef CE_GEN_RESYNC_EN
    return (c <= s) ? (c % 10 == 9) : ((c - s) % 10 == 0);
`else
    return (c % 10 == 9) && (s >= 0);
`endif
  endfunction

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ce_base !== base_exp(c, 99)) begin
        errs++;
        $display("FAIL reset ce_base cyc=%0d got=%b exp=%b", c, ce_base, base_exp(c, 99));
      end
      vecs++;
      if (ce_out !== 1'b0 || busy !== 1'b0 || remain !== '0) begin
        errs++;
        $display("FAIL reset idle cyc=%0d got out=%b busy=%b rem=%0d exp 0/0/0", c, ce_out, busy, remain);
      end
      vecs++;
      step();
    end
  endtask

  task automatic test_periodic();
    bit eo;
    do_reset();
    for (int c = 0; c <= 115; c++) begin
      start  = (c == 20);
      mode   = (c >= 60);
      period = (c >= 60) ? 8'd7 : 8'd3;
      @(negedge clk);
      eo = (c == 50 - SH) || (c == 80 - SH) || (c == 110 - SH);
      if (ce_out !== eo) begin
        errs++;
        $display("FAIL periodic ce_out cyc=%0d got=%b exp=%b", c, ce_out, eo);
      end
      vecs++;
      if (ce_base !== base_exp(c, 20)) begin
        errs++;
        $display("FAIL periodic ce_base cyc=%0d got=%b exp=%b", c, ce_base, base_exp(c, 20));
      end
      vecs++;
      if (busy !== (c >= 21)) begin
        errs++;
        $display("FAIL periodic busy cyc=%0d got=%b exp=%b", c, busy, c >= 21);
      end
      vecs++;
      if (c == 30 - SH) begin
        if (remain !== 8'd2) begin
          errs++;
          $display("FAIL periodic remain cyc=%0d got=%0d exp=2", c, remain);
        end
        vecs++;
      end
      if (c == 31 - SH) begin
        if (remain !== 8'd1) begin
          errs++;
          $display("FAIL periodic remain cyc=%0d got=%0d exp=1", c, remain);
        end
        vecs++;
      end
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_oneshot();
    bit eo;
    bit eb;
    do_reset();
    for (int c = 0; c <= 100; c++) begin
      start  = (c == 20);
      mode   = 1'b1;
      period = 8'd2;
      @(negedge clk);
      eo = (c == 40 - SH);
      eb = (c >= 21) && (c <= 40 - SH);
      if (ce_out !== eo) begin
        errs++;
        $display("FAIL oneshot ce_out cyc=%0d got=%b exp=%b", c, ce_out, eo);
      end
      vecs++;
      if (busy !== eb) begin
        errs++;
        $display("FAIL oneshot busy cyc=%0d got=%b exp=%b", c, busy, eb);
      end
      vecs++;
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_en_gap();
    bit eo;
    do_reset();
    for (int c = 0; c <= 90; c++) begin
      start  = (c == 20);
      mode   = 1'b0;
      period = 8'd3;
      en     = !(c >= 35 && c <= 39);
      @(negedge clk);
      eo = (c == 55 - SH) || (c == 85 - SH);
      if (ce_out !== eo) begin
        errs++;
        $display("FAIL en_gap ce_out cyc=%0d got=%b exp=%b", c, ce_out, eo);
      end
      vecs++;
      if (!en && ce_base !== 1'b0) begin
        errs++;
        $display("FAIL en_gap ce_base cyc=%0d got=%b exp=0", c, ce_base);
      end
      if (!en) vecs++;
      if (c == 45 - SH) begin
        if (ce_base !== 1'b1) begin
          errs++;
          $display("FAIL en_gap resume cyc=%0d got=%b exp=1", c, ce_base);
        end
        vecs++;
      end
      step();
    end
    en    = 1'b1;
    start = 1'b0;
  endtask

  task automatic test_restart();
    bit eo;
    bit eb;
    do_reset();
    for (int c = 0; c <= 85; c++) begin
      mode   = 1'b0;
      start  = (c == 9) || (c == 19) || (c == 59) || (c == 80);
      period = (c == 19) ? 8'd4 : (c == 59) ? 8'd1 : (c == 80) ? 8'd255 : 8'd0;
      @(negedge clk);
      eo = (c == 69) || (c == 79);
      eb = (c >= 20);
      if (ce_out !== eo) begin
        errs++;
        $display("FAIL restart ce_out cyc=%0d got=%b exp=%b", c, ce_out, eo);
      end
      vecs++;
      if (busy !== eb) begin
        errs++;
        $display("FAIL restart busy cyc=%0d got=%b exp=%b", c, busy, eb);
      end
      vecs++;
      if (ce_base !== base_exp(c, 80)) begin
        errs++;
        $display("FAIL restart ce_base cyc=%0d got=%b exp=%b", c, ce_base, base_exp(c, 80));
      end
      vecs++;
      if (c == 30 || c == 50 || c == 81) begin
        if (remain !== ((c == 30) ? 8'd2 : (c == 50) ? 8'd0 : 8'd254)) begin
          errs++;
          $display("FAIL restart remain cyc=%0d got=%0d exp=%0d", c, remain,
                   (c == 30) ? 2 : (c == 50) ? 0 : 254);
        end
        vecs++;
      end
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int c = 0; c <= 60; c++) begin
      rst    = (c == 45);
      start  = (c == 20) || (c == 45);
      mode   = 1'b0;
      period = (c == 45) ? 8'd5 : 8'd3;
      @(negedge clk);
      if (c >= 21 && c <= 45) begin
        if (busy !== 1'b1) begin
          errs++;
          $display("FAIL midrst busy_run cyc=%0d got=%b exp=1", c, busy);
        end
        vecs++;
      end
      if (c >= 46) begin
        if (busy !== 1'b0 || remain !== '0 || ce_out !== 1'b0) begin
          errs++;
          $display("FAIL midrst cleared cyc=%0d got busy=%b rem=%0d out=%b exp 0/0/0", c, busy, remain, ce_out);
        end
        vecs++;
        if (ce_base !== (c == 55)) begin
          errs++;
          $display("FAIL midrst ce_base cyc=%0d got=%b exp=%b", c, ce_base, c == 55);
        end
        vecs++;
      end
      step();
    end
    rst   = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    vecs   = 0;
    errs   = 0;
    rst    = 1'b1;
    en     = 1'b1;
    start  = 1'b0;
    mode   = 1'b0;
    period = '0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_en_gap();
    test_restart();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
